// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle between eight requesters and the
// round-robin arbiter.
//   req     : per-requester request levels (requester side drives)
//   grant   : registered one-hot / zero grant vector (arbiter drives)
//   busy    : OR of grant
//   preempt : one-cycle pulse after a hold-limit revocation
//   ptr     : index searched first at the next arbitration
interface rr_arbiter8_if;
    logic [7:0] req;
    logic [7:0] grant;
    logic       busy;
    logic       preempt;
    logic [2:0] ptr;

    // Requester side
    modport master (
        output req,
        input  grant, busy, preempt, ptr
    );

    // Arbiter side
    modport slave (
        input  req,
        output grant, busy, preempt, ptr
    );
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-requester round-robin arbiter with bounded grant hold.
// The grant vector feeds an 8-to-3 encoder, so it is only ever zero or
// exactly one-hot; busy separates "nothing granted" from "requester 0".
// Ports:
//   clk     : clock, all state changes on the rising edge
//   rst_n   : synchronous active-low reset
//   bus     : rr_arbiter8_if.slave (req in; grant, busy, preempt, ptr out)
// Parameter:
//   MAX_HOLD: max consecutive grant cycles per winner (0 = unlimited, <=255)
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter8_if.slave  bus
);
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
    localparam bit         LIMITED  = (MAX_HOLD != 0);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [2:0] ptr_q;
    logic [2:0] w;
    logic [7:0] hcnt;
    logic [7:0] grant_q;
    logic       busy_q;
    logic       preempt_q;
    logic [2:0] win;

    // Rotating priority search: scan offsets from the far end down so the
    // requester closest to ptr (smallest offset) is the last, winning write.
    always_comb begin
        win = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            if (bus.req[ptr_q + 3'(k)]) win = ptr_q + 3'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr_q     <= 3'd0;
            w         <= 3'd0;
            hcnt      <= 8'd0;
            grant_q   <= 8'h00;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // preempt only lives for the first idle cycle
                    preempt_q <= 1'b0;
                    if (|bus.req) begin
                        w       <= win;
                        grant_q <= 8'h01 << win;
                        busy_q  <= 1'b1;
                        hcnt    <= 8'd1;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    // Release outranks preemption when both hit the same edge.
                    if (!bus.req[w]) begin
                        grant_q   <= 8'h00;
                        busy_q    <= 1'b0;
                        ptr_q     <= w + 3'd1;
                        preempt_q <= 1'b0;
                        state     <= IDLE;
                    end else if (LIMITED && hcnt == HOLD_LIM) begin
                        grant_q   <= 8'h00;
                        busy_q    <= 1'b0;
                        ptr_q     <= w + 3'd1;
                        preempt_q <= 1'b1;
                        state     <= IDLE;
                    end else if (hcnt != 8'hFF) begin
                        // saturates; only reachable when unlimited
                        hcnt <= hcnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;
    assign bus.preempt = preempt_q;
    assign bus.ptr     = ptr_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8. Three instances share req/rst_n:
// default hold (16), MAX_HOLD=4 and MAX_HOLD=0 (unlimited).
module tb_rr_arbiter8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    rr_arbiter8_if if_def ();
    rr_arbiter8_if if_m4 ();
    rr_arbiter8_if if_m0 ();

    assign if_def.req = req;
    assign if_m4.req  = req;
    assign if_m0.req  = req;

    rr_arbiter8                 u_def (.clk(clk), .rst_n(rst_n), .bus(if_def));
    rr_arbiter8 #(.MAX_HOLD(4)) u_m4  (.clk(clk), .rst_n(rst_n), .bus(if_m4));
    rr_arbiter8 #(.MAX_HOLD(0)) u_m0  (.clk(clk), .rst_n(rst_n), .bus(if_m0));

    // One rising edge; outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = 8'h00;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req   = 8'hFF;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (if_m4.grant !== 8'h00 || if_m4.busy !== 1'b0 ||
                if_m4.preempt !== 1'b0 || if_m4.ptr !== 3'd0) begin
                errors++;
                $display("FAIL reset cyc%0d: grant=%h busy=%b preempt=%b ptr=%0d, want 00 0 0 0",
                         i, if_m4.grant, if_m4.busy, if_m4.preempt, if_m4.ptr);
            end
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (if_m4.grant !== 8'h01 || if_m4.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: grant=%h busy=%b, want 01 1", if_m4.grant, if_m4.busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h08;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (if_def.grant !== 8'h08 || if_def.busy !== 1'b1 || if_def.preempt !== 1'b0) begin
                errors++;
                $display("FAIL single_hold cyc%0d: grant=%h busy=%b preempt=%b, want 08 1 0",
                         i, if_def.grant, if_def.busy, if_def.preempt);
            end
        end
        req = 8'h00;
        step();
        checks++;
        if (if_def.grant !== 8'h00 || if_def.busy !== 1'b0 ||
            if_def.ptr !== 3'd4 || if_def.preempt !== 1'b0) begin
            errors++;
            $display("FAIL single_release: grant=%h busy=%b ptr=%0d preempt=%b, want 00 0 4 0",
                     if_def.grant, if_def.busy, if_def.ptr, if_def.preempt);
        end
    endtask

    task automatic test_saturated();
        logic [7:0] exp_g;
        do_reset();
        req = 8'hFF;
        for (int r = 0; r < 9; r++) begin
            exp_g = 8'h01 << (r % 8);
            for (int c = 0; c < 4; c++) begin
                step();
                checks++;
                if (if_m4.grant !== exp_g || if_m4.preempt !== 1'b0 || if_m4.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_hold r%0d c%0d: grant=%h preempt=%b busy=%b, want %h 0 1",
                             r, c, if_m4.grant, if_m4.preempt, if_m4.busy, exp_g);
                end
            end
            if (r < 8) begin
                step();
                checks++;
                if (if_m4.grant !== 8'h00 || if_m4.preempt !== 1'b1 ||
                    if_m4.ptr !== 3'((r + 1) % 8)) begin
                    errors++;
                    $display("FAIL sat_gap r%0d: grant=%h preempt=%b ptr=%0d, want 00 1 %0d",
                             r, if_m4.grant, if_m4.preempt, if_m4.ptr, (r + 1) % 8);
                end
            end
        end
    endtask

    task automatic test_release_vs_preempt();
        do_reset();
        req = 8'h01;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (if_m4.grant !== 8'h01) begin
            errors++;
            $display("FAIL rvp_hold: grant=%h, want 01", if_m4.grant);
        end
        // hcnt == 4 now: release and hold limit coincide at the next edge
        req = 8'h00;
        step();
        checks++;
        if (if_m4.grant !== 8'h00 || if_m4.preempt !== 1'b0 || if_m4.ptr !== 3'd1) begin
            errors++;
            $display("FAIL rvp_release: grant=%h preempt=%b ptr=%0d, want 00 0 1",
                     if_m4.grant, if_m4.preempt, if_m4.ptr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 8'h20;
        step();
        req = 8'h00;
        step();
        checks++;
        if (if_def.grant !== 8'h00 || if_def.ptr !== 3'd6) begin
            errors++;
            $display("FAIL wrap_ptr: grant=%h ptr=%0d, want 00 6", if_def.grant, if_def.ptr);
        end
        req = 8'h21;
        step();
        checks++;
        if (if_def.grant !== 8'h01) begin
            errors++;
            $display("FAIL wrap_first: grant=%h, want 01", if_def.grant);
        end
        req = 8'h00;
        step();
        req = 8'h21;
        step();
        checks++;
        if (if_def.grant !== 8'h20) begin
            errors++;
            $display("FAIL wrap_second: grant=%h, want 20", if_def.grant);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h04;
        step();
        req = 8'h00;
        step();                 // ptr -> 3
        req = 8'h10;
        step();                 // grant 10, hcnt 1
        step();                 // hcnt 2
        checks++;
        if (if_def.grant !== 8'h10) begin
            errors++;
            $display("FAIL midrst_pre: grant=%h, want 10", if_def.grant);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (if_def.grant !== 8'h00 || if_def.busy !== 1'b0 || if_def.ptr !== 3'd0) begin
            errors++;
            $display("FAIL midrst: grant=%h busy=%b ptr=%0d, want 00 0 0",
                     if_def.grant, if_def.busy, if_def.ptr);
        end
        rst_n = 1'b1;
        req   = 8'h11;
        step();
        checks++;
        if (if_def.grant !== 8'h01) begin
            errors++;
            $display("FAIL midrst_rearb: grant=%h, want 01", if_def.grant);
        end
    endtask

    task automatic test_unlimited();
        int bad = 0;
        do_reset();
        req = 8'h84;
        for (int i = 0; i < 300; i++) begin
            step();
            checks++;
            if (if_m0.grant !== 8'h04 || if_m0.preempt !== 1'b0) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL unlimited cyc%0d: grant=%h preempt=%b, want 04 0",
                             i, if_m0.grant, if_m0.preempt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturated();
        test_release_vs_preempt();
        test_wrap();
        test_reset_mid();
        test_unlimited();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
